i2c_slave_fsm: RTL

- I2C target (slave) responder for the bus driven by the team's I2C master FSM.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs, and receives write bytes or transmits read bytes MSB-first.
- Drives SDA open-drain (low or Z only) and never drives SCL; no clock stretching.

---
 rtl/i2c_slave_fsm.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target responder with oversampled SCL/SDA, START/STOP
// detection, 7-bit address match, and byte receive/transmit (MSB first).
// SDA is open-drain (low or Z), SCL is never driven, and there is no clock
// stretching.
// Optional build macro: I2C_SLAVE_GENERAL_CALL_EN. When it is defined, the
// target also accepts general-call writes (address 7'h00, rw=0).
module i2c_slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy,
    output logic       nack_seen
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    // Synchronizer chains. Stage 0 takes the raw bus pin.
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic [SYNC_STAGES-1:0] w_scl_d, w_sda_d;
    logic                   r_scl_hist, r_sda_hist;
    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_scl_d[gi] = i2c_scl;
                assign w_sda_d[gi] = i2c_sda;
            end else begin : g_rest
                assign w_scl_d[gi] = r_scl_sync[gi-1];
                assign w_sda_d[gi] = r_sda_sync[gi-1];
            end
        end
    endgenerate

    // Shift the synchronizers and history flops. They reset to the idle-bus
    // level so that releasing reset cannot produce a false START.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= w_scl_d;
            r_sda_sync <= w_sda_d;
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    assign w_start    = w_scl & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_hist & w_sda;

    // FSM and datapath registers.
    state_t      r_state, w_state_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic [6:0]  r_sh, w_sh_next;         // the last 7 bits that were sampled
    logic        r_rw, w_rw_next;
    logic [7:0]  r_tx_sh, w_tx_sh_next;   // rotated left once per transmitted bit
    logic        r_sda_low, w_sda_low_next;
    logic        r_ack_phase, w_ack_phase_next;
    logic        r_addr_match, w_addr_match_next;
    logic        r_busy, w_busy_next;
    logic [7:0]  r_rx_data, w_rx_data_next;
    logic        r_rx_valid, w_rx_valid_next;
    logic        r_tx_load, w_tx_load_next;
    logic        r_nack_seen, w_nack_seen_next;
    logic        w_addr_hit;

    // On the 8th rise of the address byte, r_sh holds the address and the
    // SDA level being sampled is the rw bit.
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign w_addr_hit = (r_sh == SLAVE_ADDR) || ((r_sh == 7'h00) && !w_sda);
`else
    assign w_addr_hit = (r_sh == SLAVE_ADDR);
`endif

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_sh         <= 7'd0;
            r_rw         <= 1'b0;
            r_tx_sh      <= 8'd0;
            r_sda_low    <= 1'b0;
            r_ack_phase  <= 1'b0;
            r_addr_match <= 1'b0;
            r_busy       <= 1'b0;
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_tx_load    <= 1'b0;
            r_nack_seen  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_sh         <= w_sh_next;
            r_rw         <= w_rw_next;
            r_tx_sh      <= w_tx_sh_next;
            r_sda_low    <= w_sda_low_next;
            r_ack_phase  <= w_ack_phase_next;
            r_addr_match <= w_addr_match_next;
            r_busy       <= w_busy_next;
            r_rx_data    <= w_rx_data_next;
            r_rx_valid   <= w_rx_valid_next;
            r_tx_load    <= w_tx_load_next;
            r_nack_seen  <= w_nack_seen_next;
        end
    end

    // Next-state logic. STOP and START take priority over the per-state
    // logic. r_ack_phase marks the second half of an ACK slot: the slot we
    // are driving low, or the master's ACK that was seen in RD_ACK.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_sh_next         = r_sh;
        w_rw_next         = r_rw;
        w_tx_sh_next      = r_tx_sh;
        w_sda_low_next    = r_sda_low;
        w_ack_phase_next  = r_ack_phase;
        w_addr_match_next = r_addr_match;
        w_busy_next       = r_busy;
        w_rx_data_next    = r_rx_data;
        w_rx_valid_next   = 1'b0;
        w_tx_load_next    = 1'b0;
        w_nack_seen_next  = 1'b0;

        if (w_stop) begin
            w_state_next      = S_IDLE;
            w_sda_low_next    = 1'b0;
            w_addr_match_next = 1'b0;
            w_busy_next       = 1'b0;
            w_ack_phase_next  = 1'b0;
        end else if (w_start) begin
            w_state_next      = S_ADDR;
            w_sda_low_next    = 1'b0;
            w_addr_match_next = 1'b0;
            w_busy_next       = 1'b1;
            w_cnt_next        = 3'd7;
            w_sh_next         = 7'd0;
            w_ack_phase_next  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_low_next = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_sh_next = {r_sh[5:0], w_sda};
                        if (r_cnt == 3'd0) begin
                            w_rw_next        = w_sda;
                            w_ack_phase_next = 1'b0;
                            w_state_next     = w_addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
                        end else begin
                            w_cnt_next = r_cnt - 3'd1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            w_sda_low_next    = 1'b1;
                            w_addr_match_next = 1'b1;
                            w_ack_phase_next  = 1'b1;
                        end else begin
                            w_ack_phase_next = 1'b0;
                            w_cnt_next       = 3'd7;
                            if (!r_rw) begin
                                w_sda_low_next = 1'b0;
                                w_state_next   = S_WR_DATA;
                            end else begin
                                w_tx_sh_next   = tx_data;
                                w_tx_load_next = 1'b1;
                                w_sda_low_next = ~tx_data[7];
                                w_state_next   = S_RD_DATA;
                            end
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_sh_next = {r_sh[5:0], w_sda};
                        if (r_cnt == 3'd0) begin
                            w_rx_data_next   = {r_sh, w_sda};
                            w_rx_valid_next  = 1'b1;
                            w_ack_phase_next = 1'b0;
                            w_state_next     = S_WR_ACK;
                        end else begin
                            w_cnt_next = r_cnt - 3'd1;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            w_sda_low_next   = 1'b1;
                            w_ack_phase_next = 1'b1;
                        end else begin
                            w_sda_low_next   = 1'b0;
                            w_ack_phase_next = 1'b0;
                            w_cnt_next       = 3'd7;
                            w_state_next     = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    // Bit 7 was put on the bus at load time. Each later fall
                    // presents the next bit, and the fall after bit 0 hands
                    // SDA back to the master for its ACK.
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd0) begin
                            w_sda_low_next   = 1'b0;
                            w_ack_phase_next = 1'b0;
                            w_state_next     = S_RD_ACK;
                        end else begin
                            w_sda_low_next = ~r_tx_sh[6];
                            w_tx_sh_next   = {r_tx_sh[6:0], r_tx_sh[7]};
                            w_cnt_next     = r_cnt - 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise && !r_ack_phase) begin
                        if (!w_sda) begin
                            w_ack_phase_next = 1'b1;
                        end else begin
                            w_nack_seen_next = 1'b1;
                            w_state_next     = S_WAIT_STOP;
                        end
                    end else if (w_scl_fall && r_ack_phase) begin
                        w_ack_phase_next = 1'b0;
                        w_tx_sh_next     = tx_data;
                        w_tx_load_next   = 1'b1;
                        w_sda_low_next   = ~tx_data[7];
                        w_cnt_next       = 3'd7;
                        w_state_next     = S_RD_DATA;
                    end
                end
                S_WAIT_STOP: begin
                    w_sda_low_next = 1'b0;
                end
                default: begin
                    w_state_next   = S_IDLE;
                    w_sda_low_next = 1'b0;
                end
            endcase
        end
    end

    // SDA is gated by reset directly so that it is released in the same
    // cycle that reset is asserted.
    assign i2c_sda    = (r_sda_low && reset) ? 1'b0 : 1'bz;
    assign tx_load    = r_tx_load;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign addr_match = r_addr_match;
    assign busy       = r_busy;
    assign nack_seen  = r_nack_seen;

endmodule
